// File: rtl/sign_extension_pipe.sv
// Decode-stage immediate generator: I/S/B/U/J build, sign-extend to XLEN,
// then STAGES valid/ready register slices with flush and illegal counting.
module sign_extension_pipe #(
    parameter int XLEN       = 32,
    parameter int INST_WIDTH = 32,
    parameter int OPCODE     = 7,
    parameter int STAGES     = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic [OPCODE-1:0]     opcode_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [XLEN-1:0]       immediate_extended_o,
    output logic                  illegal_o,
    output logic [CNT_WIDTH-1:0]  illegal_cnt_o
);

    localparam logic [OPCODE-1:0] OP_LOAD   = OPCODE'(7'b0000011);
    localparam logic [OPCODE-1:0] OP_ALUI   = OPCODE'(7'b0010011);
    localparam logic [OPCODE-1:0] OP_AUIPC  = OPCODE'(7'b0010111);
    localparam logic [OPCODE-1:0] OP_STORE  = OPCODE'(7'b0100011);
    localparam logic [OPCODE-1:0] OP_LUI    = OPCODE'(7'b0110111);
    localparam logic [OPCODE-1:0] OP_BRANCH = OPCODE'(7'b1100011);
    localparam logic [OPCODE-1:0] OP_JALR   = OPCODE'(7'b1100111);
    localparam logic [OPCODE-1:0] OP_JAL    = OPCODE'(7'b1101111);

    logic               is_i, is_s, is_b, is_u, is_j;
    logic signed [31:0] raw;
    logic [XLEN-1:0]    imm_d;
    logic               ill_d;
    logic               s;
    logic               unused;

    assign s      = inst_i[31];
    assign unused = ^inst_i[6:0];

    assign is_i = (opcode_i == OP_ALUI) | (opcode_i == OP_LOAD)
                | (opcode_i == OP_JALR);
    assign is_s = (opcode_i == OP_STORE);
    assign is_b = (opcode_i == OP_BRANCH);
    assign is_u = (opcode_i == OP_LUI) | (opcode_i == OP_AUIPC);
    assign is_j = (opcode_i == OP_JAL);

    always_comb begin
        raw   = '0;
        ill_d = 1'b0;
        unique case (1'b1)
            is_i: raw = {{20{s}}, inst_i[31:20]};
            is_s: raw = {{20{s}}, inst_i[31:25], inst_i[11:7]};
            is_b: raw = {{19{s}}, s, inst_i[7], inst_i[30:25],
                         inst_i[11:8], 1'b0};
            is_j: raw = {{11{s}}, s, inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
            is_u: raw = {inst_i[31:12], 12'b0};
            default: ill_d = 1'b1;
        endcase
    end

    // signed cast widens with sign replication (covers LUI/AUIPC at XLEN=64)
    assign imm_d = XLEN'(raw);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ill_q;
    logic [XLEN-1:0]   imm_q [STAGES];
    logic [STAGES-1:0] rdy;
    logic [STAGES:0]   vin;
    logic [STAGES:0]   ill_c;
    logic [XLEN-1:0]   imm_c [STAGES+1];
    logic              accept;
    logic [CNT_WIDTH-1:0] cnt;

    // stage k is ready unless it and every slice after it are full and stalled
    function automatic logic stage_ready(input logic [STAGES-1:0] v,
                                         input logic r, input int k);
        logic t;
        t = r;
        for (int j = STAGES - 1; j >= k; j--) t = ~v[j] | t;
        return t;
    endfunction

    always_comb begin
        for (int k = 0; k < STAGES; k++) rdy[k] = stage_ready(vld, ready_i, k);
    end

    assign vin   = {vld, valid_i};
    assign ill_c = {ill_q, ill_d};

    always_comb begin
        imm_c[0] = imm_d;
        for (int k = 0; k < STAGES; k++) imm_c[k+1] = imm_q[k];
    end

    assign accept = valid_i & rdy[0] & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld   <= '0;
            ill_q <= '0;
            cnt   <= '0;
            for (int k = 0; k < STAGES; k++) imm_q[k] <= '0;
        end else begin
            if (flush_i) vld <= '0;
            else begin
                for (int k = 0; k < STAGES; k++)
                    if (rdy[k]) vld[k] <= vin[k];
            end
            for (int k = 0; k < STAGES; k++) begin
                if (vin[k] & rdy[k] & ~flush_i) begin
                    imm_q[k] <= imm_c[k];
                    ill_q[k] <= ill_c[k];
                end
            end
            if (accept & ill_d & ~&cnt) cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign ready_o              = rdy[0];
    assign valid_o              = vld[STAGES-1];
    assign immediate_extended_o = imm_q[STAGES-1];
    assign illegal_o            = ill_q[STAGES-1];
    assign illegal_cnt_o        = cnt;

endmodule

// File: tb/tb_sign_extension_pipe.sv
// Directed bench for sign_extension_pipe: three instances
// (XLEN32/1 stage/2-bit counter, XLEN32/3 stages, XLEN64/2 stages).
module tb_sign_extension_pipe;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    typedef struct {
        logic [31:0] inst;
        logic [6:0]  op;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, valid, rdy_in;
    logic [31:0] inst;
    logic [6:0]  op;

    logic        v1, r1, il1;
    logic [31:0] imm1;
    logic [1:0]  cnt1;
    logic        v3, r3, il3;
    logic [31:0] imm3;
    logic [15:0] cnt3;
    logic        v6, r6, il6;
    logic [63:0] imm6;
    logic [15:0] cnt6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sign_extension_pipe #(.CNT_WIDTH(2)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid),
        .ready_o(r1), .inst_i(inst), .opcode_i(op), .valid_o(v1),
        .ready_i(rdy_in), .immediate_extended_o(imm1), .illegal_o(il1),
        .illegal_cnt_o(cnt1));

    sign_extension_pipe #(.STAGES(3)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid),
        .ready_o(r3), .inst_i(inst), .opcode_i(op), .valid_o(v3),
        .ready_i(rdy_in), .immediate_extended_o(imm3), .illegal_o(il3),
        .illegal_cnt_o(cnt3));

    sign_extension_pipe #(.XLEN(64), .STAGES(2)) u64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid),
        .ready_o(r6), .inst_i(inst), .opcode_i(op), .valid_o(v6),
        .ready_i(rdy_in), .immediate_extended_o(imm6), .illegal_o(il6),
        .illegal_cnt_o(cnt6));

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [11];
    int   acc, got, n;
    logic a;
    logic [1:0] sat [3];

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rdy_in = 1'b1;
        inst = '0; op = '0;

        tbl[0]  = '{32'h80000000, OP_ALUI,   32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0};
        tbl[1]  = '{32'h000170B7, OP_LUI,    32'h00017000, 64'h0000000000017000, 1'b0};
        tbl[2]  = '{32'hF19FF26F, OP_JAL,    32'hFFFFFF18, 64'hFFFFFFFFFFFFFF18, 1'b0};
        tbl[3]  = '{32'hFE4104E3, OP_BRANCH, 32'hFFFFFFE8, 64'hFFFFFFFFFFFFFFE8, 1'b0};
        tbl[4]  = '{32'h00F80023, OP_STORE,  32'h00000000, 64'h0000000000000000, 1'b0};
        tbl[5]  = '{32'h7FF12083, OP_LOAD,   32'h000007FF, 64'h00000000000007FF, 1'b0};
        tbl[6]  = '{32'hFFC08067, OP_JALR,   32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tbl[7]  = '{32'hFE112E23, OP_STORE,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tbl[8]  = '{32'h80000017, OP_AUIPC,  32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        tbl[9]  = '{32'hFFFFFF73, OP_SYS,    32'h00000000, 64'h0000000000000000, 1'b1};
        tbl[10] = '{32'h00208463, OP_BRANCH, 32'h00000008, 64'h0000000000000008, 1'b0};
        sat[0] = 2'd2; sat[1] = 2'd3; sat[2] = 2'd3;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_valid1", v1, 0);
        check("rst_imm1", imm1, 0);
        check("rst_ill1", il1, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_ready1", r1, 1);
        check("rst_valid3", v3, 0);
        check("rst_ready3", r3, 1);
        check("rst_imm64", imm6, 0);

        // single beats: stage-1 result one edge later, 64-bit two edges later
        for (int i = 0; i < 11; i++) begin
            inst = tbl[i].inst; op = tbl[i].op; valid = 1'b1;
            step();
            valid = 1'b0;
            check("tbl_valid32", v1, 1);
            check("tbl_imm32", imm1, tbl[i].e32);
            check("tbl_ill32", il1, tbl[i].ill);
            step();
            check("tbl_valid64", v6, 1);
            check("tbl_imm64", imm6, tbl[i].e64);
            check("tbl_ill64", il6, tbl[i].ill);
        end
        check("cnt_after_tbl1", cnt1, 1);
        check("cnt_after_tbl3", cnt3, 1);

        // back-to-back stream, no bubbles
        for (int i = 2; i < 5; i++) begin
            inst = tbl[i].inst; op = tbl[i].op; valid = 1'b1;
            step();
            check("b2b_valid", v1, 1);
            check("b2b_imm", imm1, tbl[i].e32);
        end
        valid = 1'b0;
        step();
        check("b2b_idle", v1, 0);

        // counter saturation at 2 bits
        for (int i = 0; i < 3; i++) begin
            inst = 32'h00000073; op = OP_SYS; valid = 1'b1;
            step();
            check("sat_cnt1", cnt1, sat[i]);
            check("sat_ill1", il1, 1);
        end
        valid = 1'b0;
        repeat (4) step();
        check("cnt3_nosat", cnt3, 4);

        // backpressure on the 3-stage instance
        rdy_in = 1'b0; n = 1; acc = 0;
        op = OP_ALUI; inst = 32'(n) << 20; valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            a = r3;
            step();
            if (a) begin
                acc++; n++;
                inst = 32'(n) << 20;
            end
            if (c >= 2) begin
                check("hold_valid", v3, 1);
                check("hold_imm", imm3, 1);
            end
        end
        check("held_beats", acc, 3);
        check("held_ready", r3, 0);
        valid = 1'b0; rdy_in = 1'b1; got = 0;
        for (int c = 0; c < 10 && got < 3; c++) begin
            if (v3) begin
                check("drain_order", imm3, 32'(got + 1));
                got++;
            end
            step();
        end
        check("drain_count", got, 3);
        check("drain_empty", v3, 0);

        // flush with two beats in flight; presented beat dropped
        op = OP_ALUI; inst = 32'h00500000; valid = 1'b1;
        step();
        inst = 32'h00600000;
        step();
        inst = 32'h00000073; op = OP_SYS; flush = 1'b1;
        step();
        flush = 1'b0; valid = 1'b0;
        check("flush_v3", v3, 0);
        check("flush_v1", v1, 0);
        check("flush_v64", v6, 0);
        check("flush_ready3", r3, 1);
        check("flush_cnt3", cnt3, 4);
        repeat (3) step();
        check("flush_stays", v3, 0);

        // asynchronous reset mid-stream
        rdy_in = 1'b0; op = OP_ALUI; inst = 32'h00900000; valid = 1'b1;
        repeat (4) step();
        check("pre_rst_v3", v3, 1);
        check("pre_rst_imm3", imm3, 9);
        rst_n = 1'b0;
        #1;
        check("arst_v3", v3, 0);
        check("arst_imm3", imm3, 0);
        check("arst_v1", v1, 0);
        check("arst_imm1", imm1, 0);
        check("arst_v64", v6, 0);
        check("arst_cnt1", cnt1, 0);
        check("arst_cnt3", cnt3, 0);
        valid = 1'b0; rdy_in = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready3", r3, 1);
        check("post_rst_v3", v3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
